inst_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the instruction ROM on behalf of the pipeline. It owns the fetch PC, drives the ROM's chip-enable and byte address, and captures each returned word with its PC into a small queue. The queue presents instructions to decode over a valid/ready handshake. It sits between the ROM and the IF/ID stage, and is the only block permitted to drive the ROM's `ce`/`addr`.

---
 rtl/mips_defs_pkg.sv | 29 ++
 rtl/inst_queue.sv | 60 ++++++
 rtl/inst_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS front end.
//   INST_W / ADDR_W    : instruction and address widths
//   RESET_PC_DEFAULT   : default first fetch address after reset
//   fetch_state_t      : fetch controller state encoding
//   fetch_entry_t      : one queued fetch result {pc, inst}
//   align_word()       : force a byte address onto a word boundary
package mips_defs;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO holding fetched {pc, inst} pairs for decode.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail (caller guarantees !full || pop)
//   push_data  : entry to write
//   pop        : drop the head entry (caller guarantees !empty)
//   flush      : discard all entries; overrides push and pop
//   head_data  : current head entry (undefined contents when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries, 0..DEPTH
module inst_queue
    import mips_defs::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head_data,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns fetch_pc, drives the instruction ROM
// and queues each returned word with its PC for the decode stage.
//   clk, rst        : clock, synchronous active-high reset
//   rom_ce/rom_addr : ROM enable (fetch cycles only) and byte address (= fetch_pc)
//   rom_inst        : ROM data, combinational from rom_ce/rom_addr
//   redirect_valid/redirect_pc : branch/jump/exception redirect, flushes the queue
//   halt            : stop fetching until the next redirect
//   if_valid/if_inst/if_pc/id_ready : queue head toward decode
//   dbg_state/dbg_count : FSM state and queue occupancy, observation only
//
// Handshake: the head entry transfers on a cycle where if_valid && id_ready;
// while if_valid && !id_ready the head (if_inst/if_pc) is held stable.
module inst_fetch_ctrl
    import mips_defs::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int                DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        rom_ce,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [INST_W-1:0]           rom_inst,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    input  logic                        halt,
    output logic                        if_valid,
    output logic [INST_W-1:0]           if_inst,
    output logic [ADDR_W-1:0]           if_pc,
    input  logic                        id_ready,
    output fetch_state_t                dbg_state,
    output logic [$clog2(DEPTH):0]      dbg_count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;

    logic              fetch;
    logic              flush;
    logic              pop;
    logic              q_pop;
    logic              push_ok;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_head;
    fetch_entry_t      q_push_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
        end
    end

    assign pop     = if_valid && id_ready;
    // A full queue can still take a word when the head leaves the same cycle.
    assign push_ok = !q_full || pop;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        fetch         = 1'b0;
        flush         = 1'b0;
        if (rst) begin
            state_next = BOOT;
        end else if (redirect_valid) begin
            // Redirect wins over halt, push and pop; no fetch this cycle.
            flush         = 1'b1;
            fetch_pc_next = align_word(redirect_pc);
            state_next    = halt ? HALT : RUN;
        end else begin
            case (state)
                BOOT: begin
                    state_next = halt ? HALT : RUN;
                end
                RUN: begin
                    if (halt) begin
                        state_next = HALT;
                    end else if (push_ok) begin
                        fetch         = 1'b1;
                        fetch_pc_next = fetch_pc + 32'd4;
                    end
                end
                HALT: begin
                    state_next = HALT;
                end
                default: begin
                    state_next = BOOT;
                end
            endcase
        end
    end

    assign q_pop            = pop && !flush;
    assign q_push_data.pc   = fetch_pc;
    assign q_push_data.inst = rom_inst;

    inst_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (flush),
        .head_data (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign rom_ce   = fetch;
    assign rom_addr = fetch_pc;

    // Head fields read as zero when nothing is queued, so stale storage
    // never leaks out after reset or flush.
    assign if_valid = !q_empty;
    assign if_inst  = q_empty ? '0 : q_head.inst;
    assign if_pc    = q_empty ? '0 : q_head.pc;

    assign dbg_state = state;
    assign dbg_count = q_count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;
  import mips_defs::*;

  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              rom_ce;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_inst;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              halt;
  logic              if_valid;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              id_ready;
  fetch_state_t      dbg_state;
  logic [1:0]        dbg_count;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .dbg_state      (dbg_state),
    .dbg_count      (dbg_count)
  );

  // ROM contents: three fixed words, everything else a distinct pattern
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0000_0000;
      32'h4: return 32'h0002_1080;
      32'h8: return 32'h3C01_0001;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  // Each cycle: inputs are driven just after the falling edge and outputs
  // are sampled 1 time unit later, well away from the rising edge.

  task automatic test_reset();
    rst = 1'b1; id_ready = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;  // cycle 0
    checks++; if (rom_ce !== 1'b0) begin failures++; $display("FAIL reset_rom_ce: got %0b want 0", rom_ce); end
    checks++; if (rom_addr !== 32'h0) begin failures++; $display("FAIL reset_rom_addr: got %h want 00000000", rom_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid: got %0b want 0", if_valid); end
    checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst: got %h want 00000000", if_inst); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
    checks++; if (dbg_state !== BOOT) begin failures++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
  endtask

  task automatic test_startup();
    @(negedge clk); #1;  // cycle 1
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin failures++; $display("FAIL start_c1_fetch: got ce=%0b addr=%h want ce=1 addr=00000000", rom_ce, rom_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL start_c1_valid: got %0b want 0", if_valid); end
    checks++; if (dbg_state !== RUN) begin failures++; $display("FAIL start_c1_state: got %0d want 1", dbg_state); end
    @(negedge clk); #1;  // cycle 2
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0) begin failures++; $display("FAIL start_c2_head: got v=%0b pc=%h inst=%h want v=1 pc=00000000 inst=00000000", if_valid, if_pc, if_inst); end
    checks++; if (rom_addr !== 32'h4) begin failures++; $display("FAIL start_c2_addr: got %h want 00000004", rom_addr); end
    @(negedge clk); #1;  // cycle 3
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h0002_1080) begin failures++; $display("FAIL start_c3_head: got v=%0b pc=%h inst=%h want v=1 pc=00000004 inst=00021080", if_valid, if_pc, if_inst); end
    @(negedge clk); #1;  // cycle 4
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'h3C01_0001) begin failures++; $display("FAIL start_c4_head: got v=%0b pc=%h inst=%h want v=1 pc=00000008 inst=3c010001", if_valid, if_pc, if_inst); end
  endtask

  task automatic test_backpressure();
    int fetches;
    logic [31:0] exp_pc;
    @(negedge clk);
    rst = 1'b1; id_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;  // cycle 0
    fetches = 0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      fetches += int'(rom_ce);
      if (k >= 2) begin
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL bp_hold_head c%0d: got v=%0b pc=%h want v=1 pc=00000000", k, if_valid, if_pc); end
      end
    end
    checks++; if (fetches != DEPTH) begin failures++; $display("FAIL bp_fetch_count: got %0d want %0d", fetches, DEPTH); end
    checks++; if (rom_ce !== 1'b0 || dbg_count !== 2'd2) begin failures++; $display("FAIL bp_full_stall: got ce=%0b count=%0d want ce=0 count=2", rom_ce, dbg_count); end
    @(negedge clk);
    id_ready = 1'b1; #1;  // cycle 5
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h8) begin failures++; $display("FAIL bp_resume_fetch: got ce=%0b addr=%h want ce=1 addr=00000008", rom_ce, rom_addr); end
    exp_pc = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_inst !== rom_word(exp_pc)) begin failures++; $display("FAIL bp_drain %0d: got v=%0b pc=%h inst=%h want v=1 pc=%h inst=%h", k, if_valid, if_pc, if_inst, exp_pc, rom_word(exp_pc)); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  // Continues from test_backpressure: queue full, id_ready high.
  task automatic test_redirect();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; #1;
    checks++; if (rom_ce !== 1'b0 || dbg_count !== 2'd2) begin failures++; $display("FAIL redir_cycle: got ce=%0b count=%0d want ce=0 count=2", rom_ce, dbg_count); end
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL redir_flushed: got v=%0b pc=%h want v=0", if_valid, if_pc); end
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h100) begin failures++; $display("FAIL redir_target_fetch: got ce=%0b addr=%h want ce=1 addr=00000100", rom_ce, rom_addr); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== rom_word(32'h100)) begin failures++; $display("FAIL redir_target_head: got v=%0b pc=%h inst=%h want v=1 pc=00000100 inst=%h", if_valid, if_pc, if_inst, rom_word(32'h100)); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h104) begin failures++; $display("FAIL redir_next_head: got v=%0b pc=%h want v=1 pc=00000104", if_valid, if_pc); end
  endtask

  // Continues from test_redirect: head 0x104, one entry queued.
  task automatic test_halt();
    @(negedge clk);
    id_ready = 1'b0; halt = 1'b1; #1;
    checks++; if (rom_ce !== 1'b0 || if_pc !== 32'h108) begin failures++; $display("FAIL halt_cycle: got ce=%0b pc=%h want ce=0 pc=00000108", rom_ce, if_pc); end
    @(negedge clk);
    halt = 1'b0; id_ready = 1'b1; #1;
    checks++; if (dbg_state !== HALT) begin failures++; $display("FAIL halt_state: got %0d want 2", dbg_state); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h108 || rom_ce !== 1'b0) begin failures++; $display("FAIL halt_keeps_entry: got v=%0b pc=%h ce=%0b want v=1 pc=00000108 ce=0", if_valid, if_pc, rom_ce); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (if_valid !== 1'b0 || rom_ce !== 1'b0) begin failures++; $display("FAIL halt_idle %0d: got v=%0b ce=%0b want v=0 ce=0", k, if_valid, rom_ce); end
    end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (if_valid !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h40) begin failures++; $display("FAIL halt_redir_fetch: got v=%0b ce=%0b addr=%h want v=0 ce=1 addr=00000040", if_valid, rom_ce, rom_addr); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin failures++; $display("FAIL halt_redir_head: got v=%0b pc=%h want v=1 pc=00000040", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top_fetch: got ce=%0b addr=%h want ce=1 addr=fffffffc", rom_ce, rom_addr); end
    @(negedge clk); #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr: got ce=%0b addr=%h want ce=1 addr=00000000", rom_ce, rom_addr); end
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top_head: got v=%0b pc=%h want v=1 pc=fffffffc", if_valid, if_pc); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL wrap_zero_head: got v=%0b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    id_ready = 1'b0; #1;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL mrst_pre_valid: got %0b want 1", if_valid); end
    @(negedge clk);
    rst = 1'b1; #1;
    @(negedge clk);
    rst = 1'b0; id_ready = 1'b1; #1;  // restart cycle 0
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin failures++; $display("FAIL mrst_head: got v=%0b pc=%h inst=%h want all 0", if_valid, if_pc, if_inst); end
    checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h0) begin failures++; $display("FAIL mrst_rom: got ce=%0b addr=%h want ce=0 addr=00000000", rom_ce, rom_addr); end
    checks++; if (dbg_state !== BOOT || dbg_count !== 2'd0) begin failures++; $display("FAIL mrst_state: got st=%0d cnt=%0d want st=0 cnt=0", dbg_state, dbg_count); end
    @(negedge clk); #1;
    checks++; if (rom_ce !== 1'b1 || rom_addr !== 32'h0 || if_valid !== 1'b0) begin failures++; $display("FAIL mrst_c1: got ce=%0b addr=%h v=%0b want ce=1 addr=00000000 v=0", rom_ce, rom_addr, if_valid); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin failures++; $display("FAIL mrst_c2: got v=%0b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
    @(negedge clk); #1;
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h0002_1080) begin failures++; $display("FAIL mrst_c3: got v=%0b pc=%h inst=%h want v=1 pc=00000004 inst=00021080", if_valid, if_pc, if_inst); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
